// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter that shares one 3-to-8 select decoder between eight
// requesters. The winner's index is registered onto sel_lines (the decoder
// inputs). grant_lines is the one-hot decode of that index while a grant is
// held. Each grant is followed by exactly one dead cycle (RELEASE) so the
// decoder outputs settle before the next holder takes over.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a holder is forcibly released after MAX_HOLD consecutive
//   GRANT cycles, and timeout_pulse marks the RELEASE cycle that follows.
//   When undefined, a grant lasts until the holder drops its request, and
//   timeout_pulse is tied to 0.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset
//   req_lines     in   [7:0] per-requester request, held high while owning
//   sel_lines     out  [2:0] registered index of the current/last grant
//   grant_lines   out  [7:0] one-hot decode of sel_lines while grant_valid
//   grant_valid   out  high while in GRANT
//   timeout_pulse out  one-cycle pulse on a forced revoke
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
   parameter int SEL_W    = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_lines,
   output logic [2:0] sel_lines,
   output logic [7:0] grant_lines,
   output logic       grant_valid,
   output logic       timeout_pulse
);

   localparam int N_REQ = 1 << SEL_W;

   // Elaboration-time guard on the configuration this block supports.
   generate
      if (SEL_W != 3) begin : g_bad_sel_w
         $error("decoder_rr_arbiter: SEL_W must be 3");
      end
      if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
         $error("decoder_rr_arbiter: MAX_HOLD must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q,   ptr_d;
   logic [SEL_W-1:0]   sel_q,   sel_d;
   logic               gv_q,    gv_d;
   logic               tp_q,    tp_d;

`ifdef ARB_TIMEOUT_EN
   logic [7:0]         hold_cnt_q, hold_cnt_d;
`endif

   logic [SEL_W:0]     pick;      // {found, index}
   logic               hold_req;  // holder's request bit

   // Rotating-priority search starting at ptr. The scan runs from the
   // farthest offset down to offset 0 so the nearest set bit is the last
   // (and therefore surviving) assignment.
   function automatic logic [SEL_W:0] rr_pick(
      input logic [N_REQ-1:0] req,
      input logic [SEL_W-1:0] ptr
   );
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + SEL_W'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign pick     = rr_pick(req_lines, ptr_q);
   assign hold_req = req_lines[sel_q];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         gv_q    <= 1'b0;
         tp_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         gv_q    <= gv_d;
         tp_q    <= tp_d;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      gv_d    = 1'b0;
      tp_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_RELEASE: begin
            if (pick[SEL_W]) begin
               state_d = ST_GRANT;
               sel_d   = pick[SEL_W-1:0];
               gv_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end else begin
               // Nothing pending: sel_lines keeps the last index.
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (!hold_req) begin
               // Voluntary release takes precedence over a same-edge timeout.
               state_d = ST_RELEASE;
               ptr_d   = sel_q + 1'b1;
`ifdef ARB_TIMEOUT_EN
            end else if (hold_cnt_q == 8'(MAX_HOLD - 1)) begin
               state_d = ST_RELEASE;
               ptr_d   = sel_q + 1'b1;
               tp_d    = 1'b1;
`endif
            end else begin
               gv_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = hold_cnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: grant_lines decodes the registered index, so it can
   // never be multi-hot and is zero whenever the grant is not held.
   always_comb begin
      grant_lines = '0;
      if (gv_q) begin
         grant_lines[sel_q] = 1'b1;
      end
   end

   assign sel_lines   = sel_q;
   assign grant_valid = gv_q;

`ifdef ARB_TIMEOUT_EN
   assign timeout_pulse = tp_q;
`else
   assign timeout_pulse = 1'b0;

   // tp_q is never set without the timeout feature; keep it referenced.
   logic tp_unused;
   assign tp_unused = tp_q;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Directed-vector bench for decoder_rr_arbiter. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, so each check sees the
// state committed by the preceding edge.
// -----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_lines;
   logic [2:0] sel_lines;
   logic [7:0] grant_lines;
   logic       grant_valid;
   logic       timeout_pulse;

   int n_cmp;
   int n_err;

   decoder_rr_arbiter #(
      .SEL_W    (3),
      .MAX_HOLD (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_lines     (req_lines),
      .sel_lines     (sel_lines),
      .grant_lines   (grant_lines),
      .grant_valid   (grant_valid),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   logic [7:0] onehot;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      req_lines = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      chk("rst_sel",   32'(sel_lines),     32'd0);
      chk("rst_grant", 32'(grant_lines),   32'h00);
      chk("rst_gv",    32'(grant_valid),   32'd0);
      chk("rst_tp",    32'(timeout_pulse), 32'd0);

      // Single request, release gap, then IDLE with sel held
      req_lines = 8'b0000_0100;
      tick();
      chk("t1_sel",   32'(sel_lines),   32'd2);
      chk("t1_grant", 32'(grant_lines), 32'h04);
      chk("t1_gv",    32'(grant_valid), 32'd1);
      req_lines = 8'h00;
      tick();
      chk("t1_rel_grant", 32'(grant_lines), 32'h00);
      chk("t1_rel_gv",    32'(grant_valid), 32'd0);
      tick();
      chk("t1_idle_grant", 32'(grant_lines), 32'h00);
      chk("t1_idle_sel",   32'(sel_lines),   32'd2);

      // Rotation with all requesting, including the 7->0 wrap
      do_reset();
      req_lines = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         onehot = 8'h01 << (k % 8);
         tick();
         chk("t2_sel",    32'(sel_lines),   32'(k % 8));
         chk("t2_grant1", 32'(grant_lines), 32'(onehot));
         tick();
         chk("t2_grant2", 32'(grant_lines), 32'(onehot));
         req_lines = 8'hFF & ~onehot;
         tick();
         chk("t2_gap", 32'(grant_lines), 32'h00);
         req_lines = 8'hFF;
      end
      req_lines = 8'h00;
      tick();
      tick();

      // Priority after release: ptr moves to 6, wraps to 0
      do_reset();
      req_lines = 8'b0010_0000;
      tick();
      chk("t3_sel5", 32'(sel_lines), 32'd5);
      req_lines = 8'b0010_0001;
      tick();
      chk("t3_hold5", 32'(grant_lines), 32'h20);
      req_lines = 8'b0000_0001;
      tick();
      chk("t3_gap", 32'(grant_lines), 32'h00);
      tick();
      chk("t3_grant0", 32'(grant_lines), 32'h01);
      chk("t3_sel0",   32'(sel_lines),   32'd0);
      req_lines = 8'h00;
      tick();
      tick();

      // No preemption by a higher-priority request raised mid-grant
      do_reset();
      req_lines = 8'b0000_0010;
      tick();
      chk("t4_grant1", 32'(grant_lines), 32'h02);
      req_lines = 8'b0000_0011;
      tick();
      chk("t4_keep_a", 32'(grant_lines), 32'h02);
      tick();
      chk("t4_keep_b", 32'(grant_lines), 32'h02);
      req_lines = 8'b0000_0001;
      tick();
      chk("t4_gap", 32'(grant_lines), 32'h00);
      tick();
      chk("t4_grant0", 32'(grant_lines), 32'h01);
      req_lines = 8'h00;
      tick();
      tick();

      // Reset mid-grant clears everything, ptr back to 0
      do_reset();
      req_lines = 8'b0100_0000;
      tick();
      chk("t5_grant6", 32'(grant_lines), 32'h40);
      rst_n = 1'b0;
      tick();
      chk("t5_rst_sel",   32'(sel_lines),     32'd0);
      chk("t5_rst_grant", 32'(grant_lines),   32'h00);
      chk("t5_rst_gv",    32'(grant_valid),   32'd0);
      chk("t5_rst_tp",    32'(timeout_pulse), 32'd0);
      rst_n     = 1'b1;
      req_lines = 8'b0100_0001;
      tick();
      chk("t5_grant0", 32'(grant_lines), 32'h01);
      req_lines = 8'h00;
      tick();
      tick();

`ifdef ARB_TIMEOUT_EN
      // Forced revoke after MAX_HOLD=4 cycles, then next requester
      do_reset();
      req_lines = 8'b0001_1000;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t6_hold3", 32'(grant_lines),   32'h08);
         chk("t6_no_tp", 32'(timeout_pulse), 32'd0);
      end
      tick();
      chk("t6_tp",      32'(timeout_pulse), 32'd1);
      chk("t6_gap",     32'(grant_lines),   32'h00);
      tick();
      chk("t6_tp_off",  32'(timeout_pulse), 32'd0);
      chk("t6_grant4",  32'(grant_lines),   32'h10);
`else
      // Without the timeout, a held grant persists and no pulse appears
      do_reset();
      req_lines = 8'b0001_1000;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("t6_hold3", 32'(grant_lines),   32'h08);
         chk("t6_no_tp", 32'(timeout_pulse), 32'd0);
      end
`endif
      req_lines = 8'h00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
Round-robin arbiter that shares one 3-to-8 select decoder between 8 requesters.
- Produces a registered 3-bit select index that drives the decoder input lines, plus a one-hot grant vector that matches the decoder output.
- Guarantees exactly one holder at a time, with a one-cycle dead gap between grants so decoder outputs settle.
- Sits between requester logic and the shared decoder datapath.

Parameters:
SEL_W, 3, select width; the requester count is 2**SEL_W (8). SEL_W is fixed at 3 for this block.
MAX_HOLD, 16, maximum number of consecutive GRANT cycles (used only with ARB_TIMEOUT_EN); legal range 1..255.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset.
req_lines  input  8  per-requester request; the holder keeps its bit high while it owns the decoder.
sel_lines  output  3  registered index of the current or last grant; drives the decoder inputs.
grant_lines  output  8  one-hot grant: decode(sel_lines) when grant_valid is 1, else 8'b0.
grant_valid  output  1  high while in GRANT.
timeout_pulse  output  1  one-cycle pulse on forced revoke; tied 0 when the feature is compiled out.

Behaviour:
- Reset: on a rising edge with rst_n=0:
  - state=IDLE, ptr=0, sel_lines=0, grant_valid=0, grant_lines=0, timeout_pulse=0, hold_cnt=0.
  - Reset during GRANT drops the grant at that edge; no RELEASE cycle is inserted.
- States:
  - IDLE: no holder; arbitrates every cycle.
  - GRANT: holder = sel_lines.
  - RELEASE: one-cycle dead gap; also arbitrates.
- Arbitration (IDLE or RELEASE):
  - Winner = first set bit of req_lines scanning ptr, ptr+1, ..., 7, 0, ..., ptr-1 (modulo 8).
  - If any request is set: at the next edge sel_lines=winner, grant_valid=1, state=GRANT.
  - Otherwise: state=IDLE, and sel_lines holds its value.
- Latency: a request sampled at edge k in IDLE produces a grant visible after edge k; i.e. one-cycle request-to-grant latency.
- GRANT:
  - If req_lines[sel_lines]=0 at an edge: state=RELEASE, grant_valid=0, ptr=sel_lines+1 (3-bit wrap, 7->0).
  - Otherwise: remain in GRANT. Other requests are ignored; there is no preemption.
- RELEASE: grant_lines=0 for exactly one cycle. Back-to-back grants are therefore separated by exactly one idle cycle.
- grant_lines is derived combinationally from the registered sel_lines and grant_valid; it is never multi-hot and never nonzero outside GRANT.
- Simultaneous requests: resolved by rotating priority only.
  - A requester that drops and re-raises its request during RELEASE is lowest priority that round.
- Requests raised mid-GRANT are held off; they are not lost as long as the requester keeps its bit high.
- Fairness: with all 8 requesting continuously, grant order is 0,1,...,7,0, ...

Optional Feature:
Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold_cnt clears on entry to GRANT and increments each GRANT cycle.
  - When hold_cnt reaches MAX_HOLD-1 and the holder's request is still high, the next edge forces RELEASE: grant_valid=0, ptr=sel_lines+1, and timeout_pulse=1 for that one cycle.
  - The revoked requester competes normally afterwards, at lowest priority.
  - A voluntary release on the same edge as the timeout counts as voluntary: no pulse.
- Undefined: no counter; GRANT lasts until the request drops; timeout_pulse is constant 0.

Test Plan:
1. Reset then req_lines=8'b0000_0100 -> after 1 edge: sel_lines=3'b010, grant_lines=8'b0000_0100, grant_valid=1. Drop the request -> grant_lines=0 for 1 cycle, then IDLE with sel_lines held at 3'b010.
2. Rotation: req_lines=8'hFF held, each holder drops for 1 cycle after 2 GRANT cycles -> grant order 0,1,2,...,7,0. Each grant lasts 2 cycles with a 1-cycle gap; the ptr wrap 7->0 is checked.
3. Priority after release: grant index 5 with req_lines=8'b0010_0001 -> bit 5 drops -> next grant is index 0 (ptr=6, wrap to 0), one cycle after RELEASE.
4. No preemption: grant index 1, then raise bit 0 -> grant_lines stays 8'b0000_0010 until bit 1 drops; index 0 is granted afterwards.
5. Reset mid-operation: rst_n=0 for 1 edge during GRANT of index 6 -> all outputs 0 at that edge. After release with req_lines=8'b0100_0001, index 0 wins (ptr reset to 0).
6. ARB_TIMEOUT_EN, MAX_HOLD=4: hold bit 3 high forever with bit 4 also high -> grant index 3 for 4 cycles, then timeout_pulse=1 for 1 cycle with grant_lines=0, then grant index 4.
